// File: rtl/pattern_detect_ctrl.sv
// Programmable serial bit-pattern detector controller.
// Ports: clk, reset (async, active-low); cfg_we/cfg_pattern/cfg_len/
//   cfg_overlap/cfg_target (configuration); start/abort (arm handshake);
//   din/din_valid (serial stream); match/match_count/busy/done/cfg_err
//   (all registered status outputs).
module pattern_detect_ctrl #(
   parameter int PAT_W = 4,
   parameter int LEN_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic             start,
   input  logic             abort,
   input  logic             din,
   input  logic             din_valid,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] C_PAT_W   = LEN_W'(PAT_W);
   localparam logic [PAT_W-1:0] C_RST_PAT = PAT_W'(4'b1011);
   localparam logic [LEN_W-1:0] C_RST_LEN = LEN_W'(4);

   state_t r_state;
   state_t w_state_nx;

   logic [PAT_W-1:0] r_pattern;
   logic [LEN_W-1:0] r_len;
   logic             r_overlap;
   logic [CNT_W-1:0] r_target;

   logic [PAT_W-1:0] r_hist;
   logic [LEN_W-1:0] r_fill;
   logic [CNT_W-1:0] r_count;

   logic r_match;
   logic r_busy;
   logic r_done;
   logic r_cfg_err;

   logic [PAT_W-1:0] w_hist_nx;
   logic [LEN_W-1:0] w_fill_nx;
   logic [CNT_W-1:0] w_count_nx;
   logic             w_match_nx;
   logic             w_busy_nx;
   logic             w_done_nx;
   logic             w_cfg_err_nx;

   logic             w_len_ok;
   logic             w_cfg_load;
   logic             w_arm;
   logic             w_sample;
   logic [PAT_W-1:0] w_hist_shift;
   logic [LEN_W-1:0] w_fill_inc;
   logic [PAT_W-1:0] w_mask;
   logic             w_hit;
   logic             w_run_match;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_tgt_hit;

   // ---------------- shared decode ----------------
   assign w_len_ok   = (cfg_len != '0) && (cfg_len <= C_PAT_W);
   assign w_cfg_load = cfg_we && w_len_ok && (r_state != S_RUN);
   assign w_arm      = (r_state != S_RUN) && start && !abort;
   assign w_sample   = (r_state == S_RUN) && !abort && din_valid;

   assign w_hist_shift = {r_hist[PAT_W-2:0], din};
   assign w_fill_inc   = (r_fill >= C_PAT_W) ? r_fill
                                             : r_fill + LEN_W'(1);

   // Low r_len bits of the history take part in the compare.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         w_mask[i] = (i < int'(r_len));
      end
   end

   assign w_hit = (w_fill_inc >= r_len) &&
                  ((w_hist_shift & w_mask) == (r_pattern & w_mask));

   assign w_run_match = w_sample && w_hit;

   // Saturating increment; target compare uses the incremented value.
   assign w_cnt_inc = (&r_count) ? r_count : r_count + CNT_W'(1);
   assign w_tgt_hit = (r_target != '0) && (w_cnt_inc == r_target);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (abort)      w_state_nx = S_IDLE;
            else if (start) w_state_nx = S_RUN;
         end
         S_RUN: begin
            if (abort)
               w_state_nx = S_IDLE;
            else if (w_run_match && w_tgt_hit)
               w_state_nx = S_DONE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_match_nx   = w_run_match;
      w_busy_nx    = (w_state_nx == S_RUN);
      w_done_nx    = (w_state_nx == S_DONE);
      // Writes are refused while running or when the length is illegal.
      w_cfg_err_nx = cfg_we && ((r_state == S_RUN) || !w_len_ok);
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      w_hist_nx  = r_hist;
      w_fill_nx  = r_fill;
      w_count_nx = r_count;
      if (w_arm) begin
         w_hist_nx  = '0;
         w_fill_nx  = '0;
         w_count_nx = '0;
      end else if (w_sample) begin
         w_hist_nx = w_hist_shift;
         w_fill_nx = w_fill_inc;
         if (w_hit) begin
            w_count_nx = w_cnt_inc;
            if (!r_overlap) begin
               w_hist_nx = '0;
               w_fill_nx = '0;
            end
         end
      end
   end

   // ---------------- configuration registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pattern <= C_RST_PAT;
         r_len     <= C_RST_LEN;
         r_overlap <= 1'b1;
         r_target  <= CNT_W'(1);
      end else if (w_cfg_load) begin
         r_pattern <= cfg_pattern;
         r_len     <= cfg_len;
         r_overlap <= cfg_overlap;
         r_target  <= cfg_target;
      end
   end

   // ---------------- history / counters ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hist  <= '0;
         r_fill  <= '0;
         r_count <= '0;
      end else begin
         r_hist  <= w_hist_nx;
         r_fill  <= w_fill_nx;
         r_count <= w_count_nx;
      end
   end

   // ---------------- registered outputs ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_match   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_match   <= w_match_nx;
         r_busy    <= w_busy_nx;
         r_done    <= w_done_nx;
         r_cfg_err <= w_cfg_err_nx;
      end
   end

   assign match       = r_match;
   assign match_count = r_count;
   assign busy        = r_busy;
   assign done        = r_done;
   assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Scoreboard bench for pattern_detect_ctrl.
// Stimulus pushes expected match counts; a negedge monitor pops them.
module tb_pattern_detect_ctrl;

   localparam int PAT_W = 4;
   localparam int LEN_W = 3;
   localparam int CNT_W = 8;

   logic             clk;
   logic             reset;
   logic             cfg_we;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic [CNT_W-1:0] cfg_target;
   logic             start;
   logic             abort;
   logic             din;
   logic             din_valid;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             busy;
   logic             done;
   logic             cfg_err;

   int n_tests = 0;
   int n_fail  = 0;
   int q_exp[$];

   pattern_detect_ctrl #(
      .PAT_W(PAT_W),
      .LEN_W(LEN_W),
      .CNT_W(CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_target  (cfg_target),
      .start       (start),
      .abort       (abort),
      .din         (din),
      .din_valid   (din_valid),
      .match       (match),
      .match_count (match_count),
      .busy        (busy),
      .done        (done),
      .cfg_err     (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every match pulse must correspond to a queued expectation.
   always @(negedge clk) begin
      if (reset === 1'b1 && match === 1'b1) begin
         n_tests++;
         if (q_exp.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_match: got count %0d expected none",
                     match_count);
         end else begin
            int e;
            e = q_exp.pop_front();
            if (int'(match_count) != e) begin
               n_fail++;
               $display("FAIL match_count_at_pulse: got %0d expected %0d",
                        match_count, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [3:0] p, input logic [2:0] l,
                      input logic ov, input logic [7:0] t);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = ov;
      cfg_target  = t;
      cfg_we      = 1'b1;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic arm();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic disarm();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // exp > 0: this bit completes a match and the count becomes exp.
   task automatic bit_in(input logic b, input int exp);
      din       = b;
      din_valid = 1'b1;
      if (exp > 0) q_exp.push_back(exp);
      tick();
   endtask

   task automatic gap();
      din       = 1'b1;
      din_valid = 1'b0;
      tick();
   endtask

   task automatic settle();
      din_valid = 1'b0;
      tick();
      tick();
      check("scoreboard_drained", q_exp.size(), 0);
   endtask

   // Stream 1,0,1,1,0,1,1 with expected counts after bits 4 and 7.
   task automatic stream7(input int e4, input int e7);
      bit_in(1'b1, 0);
      bit_in(1'b0, 0);
      bit_in(1'b1, 0);
      bit_in(1'b1, e4);
      bit_in(1'b0, 0);
      bit_in(1'b1, 0);
      bit_in(1'b1, e7);
   endtask

   initial begin
      reset       = 1'b0;
      cfg_we      = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      cfg_target  = '0;
      start       = 1'b0;
      abort       = 1'b0;
      din         = 1'b0;
      din_valid   = 1'b0;

      #2;
      check("rst_match", match, 0);
      check("rst_count", match_count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cfg_err", cfg_err, 0);
      #10 reset = 1'b1;
      tick();

      // 1: overlap, unlimited target
      cfg(4'b1011, 3'd4, 1'b1, 8'd0);
      check("t1_no_err", cfg_err, 0);
      arm();
      check("t1_busy_armed", busy, 1);
      check("t1_done_armed", done, 0);
      stream7(1, 2);
      settle();
      check("t1_count", match_count, 2);
      check("t1_busy", busy, 1);

      // 2: non-overlap
      disarm();
      check("t2_abort_busy", busy, 0);
      check("t2_abort_done", done, 0);
      check("t2_count_kept", match_count, 2);
      cfg(4'b1011, 3'd4, 1'b0, 8'd0);
      arm();
      check("t2_count_clr", match_count, 0);
      stream7(1, 0);
      settle();
      check("t2_count", match_count, 1);

      // 3: target completion
      disarm();
      cfg(4'b1011, 3'd4, 1'b1, 8'd2);
      arm();
      stream7(1, 2);
      check("t3_done", done, 1);
      check("t3_busy", busy, 0);
      check("t3_count", match_count, 2);
      bit_in(1'b0, 0);
      bit_in(1'b1, 0);
      bit_in(1'b1, 0);
      settle();
      check("t3_count_held", match_count, 2);
      check("t3_done_held", done, 1);

      // 4: rejected configuration writes
      arm();
      check("t4_rearm_busy", busy, 1);
      check("t4_rearm_done", done, 0);
      check("t4_rearm_count", match_count, 0);
      cfg(4'b0000, 3'd2, 1'b0, 8'd0);
      check("t4_err_run", cfg_err, 1);
      tick();
      check("t4_err_run_clr", cfg_err, 0);
      disarm();
      cfg(4'b0000, 3'd0, 1'b0, 8'd0);
      check("t4_err_len0", cfg_err, 1);
      tick();
      check("t4_err_len0_clr", cfg_err, 0);
      arm();
      bit_in(1'b1, 0);
      bit_in(1'b0, 0);
      bit_in(1'b1, 0);
      bit_in(1'b1, 1);
      settle();
      check("t4_count", match_count, 1);
      check("t4_busy", busy, 1);

      // 5: abort on completing bit, then gapped stream
      disarm();
      arm();
      bit_in(1'b1, 0);
      bit_in(1'b0, 0);
      bit_in(1'b1, 0);
      abort = 1'b1;
      bit_in(1'b1, 0);
      abort = 1'b0;
      check("t5_abort_busy", busy, 0);
      check("t5_abort_count", match_count, 0);
      settle();
      arm();
      bit_in(1'b1, 0);
      gap();
      bit_in(1'b0, 0);
      gap();
      gap();
      bit_in(1'b1, 0);
      gap();
      bit_in(1'b1, 1);
      settle();
      check("t5_gap_count", match_count, 1);

      // 6: reset mid-run
      disarm();
      cfg(4'b1011, 3'd4, 1'b1, 8'd0);
      arm();
      stream7(1, 2);
      bit_in(1'b0, 0);
      bit_in(1'b1, 0);
      bit_in(1'b1, 3);
      settle();
      check("t6_count3", match_count, 3);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_count", match_count, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
      check("t6_rst_match", match, 0);
      reset = 1'b1;
      tick();
      // Default config: 1011, len 4, target 1 -> done after first match.
      arm();
      bit_in(1'b1, 0);
      bit_in(1'b0, 0);
      bit_in(1'b1, 0);
      bit_in(1'b1, 1);
      check("t6_dflt_done", done, 1);
      check("t6_dflt_busy", busy, 0);
      settle();
      check("t6_dflt_count", match_count, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
